spi_mem_arbiter: RTL and testbench
==================================

// Module: spi_mem_arbiter
// PURPOSE
//   Shares the single external SPI flash between two read requesters: the
//   instruction-fetch port (program counter side) and the data-load port
//   (data memory refill). Arbitrates, then runs one complete SPI READ (0x03)
//   transaction per grant. Sits between the CPU memory ports and uio[3:0].
// PARAMETERS
//   CLK_DIV       2          clk cycles per SCLK half-period (>=1)
//   STARVE_LIMIT  4          max consecutive data grants while fetch waits
//   IF_BASE       24'h000000 flash byte base of the program image
//   D_BASE        24'h010000 flash byte base of the data image
// PORTS
//   clk          in   1   system clock
//   rst          in   1   asynchronous reset, active-high
//   if_req       in   1   fetch request, level, held until if_ack
//   if_addr      in   16  fetch word address, stable while if_req=1
//   if_rdata     out  16  fetched instruction word
//   if_ack       out  1   1-cycle pulse: if_rdata valid
//   d_req        in   1   data request, level, held until d_ack
//   d_addr       in   16  data byte address, stable while d_req=1
//   d_rdata      out  8   fetched data byte
//   d_ack        out  1   1-cycle pulse: d_rdata valid
//   busy         out  1   1 from grant until the end of CS_GAP
//   spi_cs       out  1   flash chip select, active-low
//   spi_sclk     out  1   SPI clock, mode 0 (idles low)
//   spi_mosi     out  1   command/address out, MSB first
//   spi_mosi_oe  out  1   1 in CMD/ADDR, 0 otherwise
//   spi_miso     in   1   flash data in
// BEHAVIOUR
// - Reset (async, any state): spi_cs=1, spi_sclk=0, spi_mosi=0,
//   spi_mosi_oe=0, if_ack=d_ack=0, busy=0, if_rdata=0, d_rdata=0,
//   starve counter=0, state=IDLE. An aborted transfer is never acked.
// - FSM: IDLE -> CS_SETUP(1 clk, cs=0) -> CMD(8 bits) -> ADDR(24 bits) ->
//   DATA(16 bits fetch / 8 bits data) -> CS_HOLD(1 clk, cs still 0) ->
//   CS_GAP(2 clk, cs=1; ack pulses on the first CS_GAP cycle) -> IDLE.
// - Arbitration happens only in IDLE, 1 clk after the request is seen:
//   d_req wins over if_req, except that when starve count == STARVE_LIMIT
//   and if_req=1, fetch wins. Starve count increments on each data grant
//   made while if_req=1, saturates at STARVE_LIMIT, clears on fetch grant.
// - Flash address, latched at grant: fetch = IF_BASE + {8'h0,if_addr,1'b0};
//   data = D_BASE + {8'h0,d_addr}; 24-bit add, wraps modulo 2^24.
// - SPI timing: each bit = 2*CLK_DIV clk. MOSI updates while SCLK is low
//   (at the start of the bit); MISO sampled on the SCLK rising edge.
//   SCLK is low in CS_SETUP, CS_HOLD and CS_GAP.
// - Fetch data: first received byte -> if_rdata[15:8], second -> [7:0].
// - if_rdata/d_rdata update only on their own ack; held otherwise.
// - Latency grant->ack, CLK_DIV=2: fetch 1+48*4+1 = 194 clk;
//   data 1+40*4+1 = 162 clk. Plus the 1 arbitration cycle.
// - if_ack and d_ack are never high together; at most one ack per grant.
// - A requester dropping req mid-transfer: the transfer completes and the
//   ack still pulses. A req still high in the gap is re-arbitrated in IDLE
//   (a new transfer is started).
// - Address changes while req=1 are ignored after grant.
// STRUCTURE
// - defines.vh gets: SPI_CMD_READ=8'h03, FSM state encodings (3 bits),
//   bit-count widths.
// - One sub-module: spi_bit_engine. It holds the CLK_DIV prescaler,
//   SCLK generation, a 24-bit shift-out and a 16-bit shift-in. Handshake:
//   start/nbits/done. spi_mem_arbiter keeps the FSM, arbiter, starve counter
//   and output registers.
// TESTING
// 1 rst=1 held 5 clk, then released -> all outputs at reset values;
//   spi_cs=1 with no request.
// 2 if_req, if_addr=16'h0012, flash model returns 16'hA55A -> MOSI stream
//   03 00 00 24; if_ack after 195 clk; if_rdata=16'hA55A.
// 3 d_req, d_addr=16'h00FF, flash returns 8'h3C -> address 01 00 FF;
//   d_ack pulses once; d_rdata=8'h3C; if_rdata unchanged.
// 4 if_req and d_req held high continuously -> grant order D,D,D,D,F,
//   D,D,D,D,F; no two acks in the same cycle.
// 5 rst asserted 100 clk into a fetch -> spi_cs=1 in the same cycle; no
//   ack; next fetch after release completes with correct data.
// 6 if_addr=16'hFFFF with IF_BASE=24'hFF0000 -> flash address 24'h00FFFE
//   (24-bit wrap); d_req dropped mid-transfer -> d_ack still pulses once.

Source files
------------

// File: rtl/spi_mem_arbiter_pkg.sv
// Shared constants, FSM encoding and address helper for the SPI flash
// read arbiter.
package spi_mem_arbiter_pkg;

  localparam logic [7:0] SPI_CMD_READ = 8'h03;
  localparam int         CNT_W        = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_CMD,
    S_ADDR,
    S_DATA,
    S_HOLD,
    S_GAP1,
    S_GAP2
  } state_t;

  // Fetch word address to flash byte address; wraps modulo 2^24.
  function automatic logic [23:0] fetch_addr(
    input logic [23:0] base,
    input logic [15:0] a
  );
    return base + {7'h0, a, 1'b0};
  endfunction

endpackage

// File: rtl/spi_mem_arbiter_spi_bit_engine.sv
// SPI mode-0 bit engine: prescaler, SCLK, 24-bit shift-out, 16-bit
// shift-in. A start in the done cycle chains with no idle gap.
module spi_bit_engine
  import spi_mem_arbiter_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] nbits,
  input  logic [23:0]      din,
  input  logic             miso,
  output logic             sclk,
  output logic             mosi,
  output logic             done,
  output logic [15:0]      dout
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic             active_q, active_d;
  logic             ph_q, ph_d;
  logic [DW-1:0]    div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [23:0]      so_q, so_d;
  logic [15:0]      si_q, si_d;
  logic             tick;

  assign tick = (div_q == DW'(CLK_DIV - 1));

  always_comb begin
    active_d = active_q;
    ph_d     = ph_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    so_d     = so_q;
    si_d     = si_q;
    done     = active_q && ph_q && tick
               && (cnt_q == CNT_W'(1));
    if (active_q) begin
      if (tick) begin
        div_d = '0;
        ph_d  = !ph_q;
        if (!ph_q) begin
          si_d = {si_q[14:0], miso};
        end else begin
          so_d  = {so_q[22:0], 1'b0};
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) active_d = 1'b0;
        end
      end else begin
        div_d = div_q + DW'(1);
      end
    end
    if (start) begin
      active_d = 1'b1;
      ph_d     = 1'b0;
      div_d    = '0;
      cnt_d    = nbits;
      so_d     = din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      ph_q     <= 1'b0;
      div_q    <= '0;
      cnt_q    <= '0;
      so_q     <= '0;
      si_q     <= '0;
    end else begin
      active_q <= active_d;
      ph_q     <= ph_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      so_q     <= so_d;
      si_q     <= si_d;
    end
  end

  assign sclk = active_q & ph_q;
  assign mosi = active_q & so_q[23];
  assign dout = si_q;

endmodule

// File: rtl/spi_mem_arbiter.sv
// Arbitrates fetch and data read ports onto one SPI flash and runs
// one READ (0x03) transaction per grant.
module spi_mem_arbiter
  import spi_mem_arbiter_pkg::*;
#(
  parameter int          CLK_DIV      = 2,
  parameter int          STARVE_LIMIT = 4,
  parameter logic [23:0] IF_BASE      = 24'h000000,
  parameter logic [23:0] D_BASE       = 24'h010000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_ack,
  input  logic        d_req,
  input  logic [15:0] d_addr,
  output logic [7:0]  d_rdata,
  output logic        d_ack,
  output logic        busy,
  output logic        spi_cs,
  output logic        spi_sclk,
  output logic        spi_mosi,
  output logic        spi_mosi_oe,
  input  logic        spi_miso
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  state_t           state_q, state_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic [23:0]      addr_q, addr_d;
  logic             fetch_q, fetch_d;
  logic [15:0]      if_rdata_q, if_rdata_d;
  logic [7:0]       d_rdata_q, d_rdata_d;
  logic             if_ack_q, if_ack_d;
  logic             d_ack_q, d_ack_d;
  logic             starved;
  logic             start, done;
  logic [CNT_W-1:0] nbits;
  logic [23:0]      din;
  logic [15:0]      dout;
  logic             eng_sclk, eng_mosi;

  assign starved = if_req && (starve_q == SW'(STARVE_LIMIT));

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    addr_d     = addr_q;
    fetch_d    = fetch_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_ack_d   = 1'b0;
    d_ack_d    = 1'b0;
    start      = 1'b0;
    nbits      = '0;
    din        = '0;
    unique case (state_q)
      S_IDLE: begin
        if (d_req && !starved) begin
          fetch_d = 1'b0;
          addr_d  = D_BASE + {8'h0, d_addr};
          state_d = S_SETUP;
          if (if_req) starve_d = starve_q + SW'(1);
        end else if (if_req) begin
          fetch_d  = 1'b1;
          addr_d   = fetch_addr(IF_BASE, if_addr);
          starve_d = '0;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        start   = 1'b1;
        nbits   = CNT_W'(8);
        din     = {SPI_CMD_READ, 16'h0};
        state_d = S_CMD;
      end
      S_CMD: begin
        if (done) begin
          start   = 1'b1;
          nbits   = CNT_W'(24);
          din     = addr_q;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (done) begin
          start   = 1'b1;
          nbits   = fetch_q ? CNT_W'(16) : CNT_W'(8);
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (done) state_d = S_HOLD;
      end
      S_HOLD: begin
        state_d = S_GAP1;
        if (fetch_q) begin
          if_ack_d   = 1'b1;
          if_rdata_d = dout;
        end else begin
          d_ack_d   = 1'b1;
          d_rdata_d = dout[7:0];
        end
      end
      S_GAP1: state_d = S_GAP2;
      S_GAP2: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      starve_q   <= '0;
      addr_q     <= '0;
      fetch_q    <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      addr_q     <= addr_d;
      fetch_q    <= fetch_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_ack_q   <= if_ack_d;
      d_ack_q    <= d_ack_d;
    end
  end

  spi_bit_engine #(
    .CLK_DIV(CLK_DIV)
  ) u_eng (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .nbits(nbits),
    .din  (din),
    .miso (spi_miso),
    .sclk (eng_sclk),
    .mosi (eng_mosi),
    .done (done),
    .dout (dout)
  );

  // CS decodes straight from state so an async reset releases it at once.
  assign spi_cs = !((state_q == S_SETUP) || (state_q == S_CMD)
                 || (state_q == S_ADDR) || (state_q == S_DATA)
                 || (state_q == S_HOLD));
  assign spi_mosi_oe = (state_q == S_CMD) || (state_q == S_ADDR);
  assign spi_mosi    = spi_mosi_oe & eng_mosi;
  assign spi_sclk    = eng_sclk;
  assign busy        = (state_q != S_IDLE);
  assign if_rdata    = if_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign if_ack      = if_ack_q;
  assign d_ack       = d_ack_q;

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Directed bench for spi_mem_arbiter with a behavioural mode-0 flash
// model; a second instance covers the 24-bit address wrap.
module tb_spi_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = '0;
  logic [15:0] if_rdata;
  logic        if_ack;
  logic        d_req = 1'b0;
  logic [15:0] d_addr = '0;
  logic [7:0]  d_rdata;
  logic        d_ack;
  logic        busy;
  logic        spi_cs;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        spi_mosi_oe;
  logic        miso = 1'b0;

  logic        w_if_req = 1'b0;
  logic [15:0] w_if_addr = '0;
  logic [15:0] w_if_rdata;
  logic        w_if_ack;
  logic        w_d_req = 1'b0;
  logic [15:0] w_d_addr = '0;
  logic [7:0]  w_d_rdata;
  logic        w_d_ack;
  logic        w_busy;
  logic        w_cs;
  logic        w_sclk;
  logic        w_mosi;
  logic        w_oe;
  logic        w_miso = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spi_mem_arbiter u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_addr(d_addr),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .busy(busy), .spi_cs(spi_cs),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .spi_mosi_oe(spi_mosi_oe), .spi_miso(miso)
  );

  spi_mem_arbiter #(
    .IF_BASE(24'hFF0000)
  ) u_wrap (
    .clk(clk), .rst(rst),
    .if_req(w_if_req), .if_addr(w_if_addr),
    .if_rdata(w_if_rdata), .if_ack(w_if_ack),
    .d_req(w_d_req), .d_addr(w_d_addr),
    .d_rdata(w_d_rdata), .d_ack(w_d_ack),
    .busy(w_busy), .spi_cs(w_cs),
    .spi_sclk(w_sclk), .spi_mosi(w_mosi),
    .spi_mosi_oe(w_oe), .spi_miso(w_miso)
  );

  // Flash model: captures 32 cmd/addr bits, then shifts resp out.
  int          bitcnt = 0;
  logic [31:0] cap = '0;
  logic [15:0] resp = '0;

  always @(posedge spi_cs) bitcnt = 0;

  always @(posedge spi_sclk) begin
    if (bitcnt < 32) cap = {cap[30:0], spi_mosi};
    bitcnt++;
  end

  always @(negedge spi_sclk) begin
    if (bitcnt >= 32 && bitcnt < 48) miso = resp[47 - bitcnt];
  end

  int          bitcnt2 = 0;
  logic [31:0] cap2 = '0;

  always @(posedge w_cs) bitcnt2 = 0;

  always @(posedge w_sclk) begin
    if (bitcnt2 < 32) cap2 = {cap2[30:0], w_mosi};
    bitcnt2++;
  end

  int if_ack_cnt = 0;
  int d_ack_cnt = 0;

  always @(posedge clk) begin
    if (if_ack === 1'b1) if_ack_cnt++;
    if (d_ack === 1'b1) d_ack_cnt++;
  end

  task automatic test_reset;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({spi_cs, spi_sclk, spi_mosi, spi_mosi_oe,
         if_ack, d_ack, busy} !== 7'b1000000) begin
      failures++;
      $display("FAIL reset_ctl got=%b want=1000000",
               {spi_cs, spi_sclk, spi_mosi, spi_mosi_oe,
                if_ack, d_ack, busy});
    end
    checks++;
    if ({if_rdata, d_rdata} !== 24'h0) begin
      failures++;
      $display("FAIL reset_data got=%h want=000000",
               {if_rdata, d_rdata});
    end
  endtask

  task automatic test_fetch;
    int n;
    resp = 16'hA55A;
    @(posedge clk);
    #1 if_addr = 16'h0012;
    if_req = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!if_ack && n < 400);
    if_req = 1'b0;
    checks++;
    if (n !== 195) begin
      failures++;
      $display("FAIL fetch_latency got=%0d want=195", n);
    end
    checks++;
    if (if_rdata !== 16'hA55A) begin
      failures++;
      $display("FAIL fetch_data got=%h want=a55a", if_rdata);
    end
    checks++;
    if (cap !== 32'h03000024) begin
      failures++;
      $display("FAIL fetch_mosi got=%h want=03000024", cap);
    end
    @(posedge clk);
    #1;
    checks++;
    if (if_ack !== 1'b0) begin
      failures++;
      $display("FAIL fetch_ack_pulse got=%b want=0", if_ack);
    end
    repeat (4) @(posedge clk);
  endtask

  task automatic test_data;
    int n;
    int a0;
    resp = 16'h3C00;
    a0 = d_ack_cnt;
    @(posedge clk);
    #1 d_addr = 16'h00FF;
    d_req = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!d_ack && n < 400);
    d_req = 1'b0;
    checks++;
    if (n !== 163) begin
      failures++;
      $display("FAIL data_latency got=%0d want=163", n);
    end
    checks++;
    if (d_rdata !== 8'h3C) begin
      failures++;
      $display("FAIL data_byte got=%h want=3c", d_rdata);
    end
    checks++;
    if (cap !== 32'h030100FF) begin
      failures++;
      $display("FAIL data_mosi got=%h want=030100ff", cap);
    end
    checks++;
    if (if_rdata !== 16'hA55A) begin
      failures++;
      $display("FAIL data_if_hold got=%h want=a55a", if_rdata);
    end
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (d_ack_cnt - a0 !== 1) begin
      failures++;
      $display("FAIL data_ack_once got=%0d want=1",
               d_ack_cnt - a0);
    end
  endtask

  task automatic test_back_to_back;
    logic [9:0] seq;
    int n;
    int both;
    int cyc;
    seq = '0;
    resp = 16'hA55A;
    @(posedge clk);
    #1 if_addr = 16'h0000;
    d_addr = 16'h0000;
    if_req = 1'b1;
    d_req = 1'b1;
    n = 0;
    both = 0;
    cyc = 0;
    while (n < 10 && cyc < 4000) begin
      @(posedge clk);
      #1 cyc++;
      if (if_ack && d_ack) both++;
      if (if_ack || d_ack) begin
        seq[9 - n] = if_ack;
        n++;
      end
    end
    if_req = 1'b0;
    d_req = 1'b0;
    checks++;
    if (n !== 10) begin
      failures++;
      $display("FAIL b2b_count got=%0d want=10", n);
    end
    checks++;
    if (seq !== 10'b0000100001) begin
      failures++;
      $display("FAIL b2b_order got=%b want=0000100001", seq);
    end
    checks++;
    if (both !== 0) begin
      failures++;
      $display("FAIL b2b_dual_ack got=%0d want=0", both);
    end
    cyc = 0;
    while (busy && cyc < 20) begin
      @(posedge clk);
      #1 cyc++;
    end
  endtask

  task automatic test_reset_abort;
    int a0;
    int n;
    resp = 16'hBEEF;
    @(posedge clk);
    #1 if_addr = 16'h0100;
    if_req = 1'b1;
    repeat (100) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({spi_cs, spi_sclk, busy} !== 3'b100) begin
      failures++;
      $display("FAIL abort_cs got=%b want=100",
               {spi_cs, spi_sclk, busy});
    end
    if_req = 1'b0;
    a0 = if_ack_cnt;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    checks++;
    if (if_ack_cnt !== a0) begin
      failures++;
      $display("FAIL abort_no_ack got=%0d want=%0d",
               if_ack_cnt, a0);
    end
    checks++;
    if (if_rdata !== 16'h0000) begin
      failures++;
      $display("FAIL abort_rdata got=%h want=0000", if_rdata);
    end
    resp = 16'h1234;
    if_addr = 16'h0200;
    if_req = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!if_ack && n < 400);
    if_req = 1'b0;
    checks++;
    if (if_rdata !== 16'h1234 || n >= 400) begin
      failures++;
      $display("FAIL abort_refetch got=%h want=1234 cyc=%0d",
               if_rdata, n);
    end
    checks++;
    if (cap !== 32'h03000400) begin
      failures++;
      $display("FAIL abort_mosi got=%h want=03000400", cap);
    end
    repeat (4) @(posedge clk);
  endtask

  task automatic test_drop;
    int a0;
    resp = 16'h7700;
    a0 = d_ack_cnt;
    @(posedge clk);
    #1 d_addr = 16'h0010;
    d_req = 1'b1;
    repeat (50) @(posedge clk);
    #1 d_req = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL drop_busy got=%b want=1", busy);
    end
    repeat (250) @(posedge clk);
    #1;
    checks++;
    if (d_ack_cnt - a0 !== 1) begin
      failures++;
      $display("FAIL drop_ack_once got=%0d want=1",
               d_ack_cnt - a0);
    end
    checks++;
    if (d_rdata !== 8'h77) begin
      failures++;
      $display("FAIL drop_byte got=%h want=77", d_rdata);
    end
    checks++;
    if (cap !== 32'h03010010) begin
      failures++;
      $display("FAIL drop_mosi got=%h want=03010010", cap);
    end
  endtask

  task automatic test_wrap;
    int n;
    @(posedge clk);
    #1 w_if_addr = 16'hFFFF;
    w_if_req = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!w_if_ack && n < 400);
    w_if_req = 1'b0;
    checks++;
    if (n !== 195) begin
      failures++;
      $display("FAIL wrap_latency got=%0d want=195", n);
    end
    checks++;
    if (cap2 !== 32'h0300FFFE) begin
      failures++;
      $display("FAIL wrap_addr got=%h want=0300fffe", cap2);
    end
    checks++;
    if (w_if_rdata !== 16'h0000) begin
      failures++;
      $display("FAIL wrap_data got=%h want=0000", w_if_rdata);
    end
  endtask

  initial begin
    test_reset;
    test_fetch;
    test_data;
    test_back_to_back;
    test_reset_abort;
    test_drop;
    test_wrap;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
